// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - round-robin data-memory port arbiter for CPU and NIC
module dmem_port_arbiter #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [0:31] cpu_addr,
  input  logic [0:63] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [0:63] cpu_rdata,
  input  logic        nic_req,
  input  logic        nic_we,
  input  logic [0:31] nic_addr,
  input  logic [0:63] nic_wdata,
  output logic        nic_gnt,
  output logic        nic_rvalid,
  output logic [0:63] nic_rdata,
  output logic        memEn,
  output logic        memWrEn,
  output logic [0:31] addr_out,
  output logic [0:63] d_out,
  input  logic [0:63] d_in
);

  // prio: 0 = CPU wins a tie, 1 = NIC wins a tie
  logic        prio;
  logic        any_gnt;
  logic        sel_we;
  logic [0:31] sel_addr;
  logic [0:63] sel_wdata;

  // Read tag riding alongside the command register, then RD_LAT stages
  // so the tag reaches the output in the same cycle as d_in.
  logic              cmd_rd;
  logic              cmd_port;
  logic [RD_LAT-1:0] trk_vld;
  logic [RD_LAT-1:0] trk_port;

  // Combinational arbitration and selection of the granted request
  always_comb begin
    cpu_gnt   = cpu_req & (~nic_req | ~prio);
    nic_gnt   = nic_req & (~cpu_req | prio);
    any_gnt   = cpu_gnt | nic_gnt;
    sel_we    = nic_gnt ? nic_we    : cpu_we;
    sel_addr  = nic_gnt ? nic_addr  : cpu_addr;
    sel_wdata = nic_gnt ? nic_wdata : cpu_wdata;
  end

  // Round-robin pointer: after any grant the other port gets the next tie
  always_ff @(posedge clk) begin
    if (reset) begin
      prio <= 1'b0;
    end else if (any_gnt) begin
      prio <= cpu_gnt;
    end
  end

  // Registered memory command; idle cycles and reads drive zero write data
  always_ff @(posedge clk) begin
    if (reset) begin
      memEn    <= 1'b0;
      memWrEn  <= 1'b0;
      addr_out <= '0;
      d_out    <= '0;
      cmd_rd   <= 1'b0;
      cmd_port <= 1'b0;
    end else begin
      memEn    <= any_gnt;
      memWrEn  <= any_gnt & sel_we;
      addr_out <= any_gnt ? sel_addr : '0;
      d_out    <= (any_gnt & sel_we) ? sel_wdata : '0;
      cmd_rd   <= any_gnt & ~sel_we;
      cmd_port <= nic_gnt;
    end
  end

  // Latency pipeline for outstanding reads; cleared on reset so in-flight reads vanish
  always_ff @(posedge clk) begin
    if (reset) begin
      trk_vld  <= '0;
      trk_port <= '0;
    end else begin
      trk_vld[0]  <= cmd_rd;
      trk_port[0] <= cmd_port;
      for (int i = 1; i < RD_LAT; i++) begin
        trk_vld[i]  <= trk_vld[i-1];
        trk_port[i] <= trk_port[i-1];
      end
    end
  end

  // Return steering: the oldest read tag selects which port sees d_in
  always_comb begin
    cpu_rvalid = trk_vld[RD_LAT-1] & ~trk_port[RD_LAT-1];
    nic_rvalid = trk_vld[RD_LAT-1] &  trk_port[RD_LAT-1];
    cpu_rdata  = d_in;
    nic_rdata  = d_in;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - scoreboard bench for dmem_port_arbiter at RD_LAT 1 and 3
module tb_dmem_port_arbiter;

  typedef struct {
    logic        port;
    logic [63:0] data;
    int          due;
  } ret_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, nic_req = 1'b0, nic_we = 1'b0;
  logic [0:31] cpu_addr = '0, nic_addr = '0;
  logic [0:63] cpu_wdata = '0, nic_wdata = '0;

  logic        cpu_gnt1, cpu_rvalid1, nic_gnt1, nic_rvalid1, memEn1, memWrEn1;
  logic [0:63] cpu_rdata1, nic_rdata1, d_out1, d_in1;
  logic [0:31] addr_out1;
  logic        cpu_gnt3, cpu_rvalid3, nic_gnt3, nic_rvalid3, memEn3, memWrEn3;
  logic [0:63] cpu_rdata3, nic_rdata3, d_out3, d_in3;
  logic [0:31] addr_out3;

  logic [0:31] p1 = '0, p3a = '0, p3b = '0, p3c = '0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        mprio = 1'b0;
  ret_t        q1[$];
  ret_t        q3[$];

  always #5 clk = ~clk;

  dmem_port_arbiter #(.RD_LAT(1)) u1 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt1), .cpu_rvalid(cpu_rvalid1), .cpu_rdata(cpu_rdata1),
    .nic_req(nic_req), .nic_we(nic_we), .nic_addr(nic_addr), .nic_wdata(nic_wdata),
    .nic_gnt(nic_gnt1), .nic_rvalid(nic_rvalid1), .nic_rdata(nic_rdata1),
    .memEn(memEn1), .memWrEn(memWrEn1), .addr_out(addr_out1), .d_out(d_out1), .d_in(d_in1)
  );

  dmem_port_arbiter #(.RD_LAT(3)) u3 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt3), .cpu_rvalid(cpu_rvalid3), .cpu_rdata(cpu_rdata3),
    .nic_req(nic_req), .nic_we(nic_we), .nic_addr(nic_addr), .nic_wdata(nic_wdata),
    .nic_gnt(nic_gnt3), .nic_rvalid(nic_rvalid3), .nic_rdata(nic_rdata3),
    .memEn(memEn3), .memWrEn(memWrEn3), .addr_out(addr_out3), .d_out(d_out3), .d_in(d_in3)
  );

  function automatic logic [0:63] memfn(input logic [0:31] a);
    if (a == 32'h10) return 64'hDEAD_BEEF;
    return {a ^ 32'hA5A5_0000, ~a};
  endfunction

  // Memory models: data for the address commanded RD_LAT cycles earlier
  always @(posedge clk) begin
    cyc <= cyc + 1;
    p1  <= addr_out1;
    p3a <= addr_out3;
    p3b <= p3a;
    p3c <= p3b;
  end
  assign d_in1 = memfn(p1);
  assign d_in3 = memfn(p3c);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Return monitor, RD_LAT = 1
  always @(negedge clk) begin
    ret_t e;
    if (cpu_rvalid1 === 1'b1 || nic_rvalid1 === 1'b1) begin
      chk("l1_rvalid_excl", cpu_rvalid1 & nic_rvalid1, 0);
      if (q1.size() == 0) chk("l1_unexpected_rvalid", 1, 0);
      else begin
        e = q1.pop_front();
        chk("l1_ret_port", nic_rvalid1, e.port);
        chk("l1_ret_data", nic_rvalid1 ? nic_rdata1 : cpu_rdata1, e.data);
        chk("l1_ret_cycle", cyc, e.due);
      end
    end
    while (q1.size() > 0 && q1[0].due < cyc) begin
      chk("l1_missing_rvalid", cyc, q1[0].due);
      void'(q1.pop_front());
    end
  end

  // Return monitor, RD_LAT = 3
  always @(negedge clk) begin
    ret_t e;
    if (cpu_rvalid3 === 1'b1 || nic_rvalid3 === 1'b1) begin
      chk("l3_rvalid_excl", cpu_rvalid3 & nic_rvalid3, 0);
      if (q3.size() == 0) chk("l3_unexpected_rvalid", 1, 0);
      else begin
        e = q3.pop_front();
        chk("l3_ret_port", nic_rvalid3, e.port);
        chk("l3_ret_data", nic_rvalid3 ? nic_rdata3 : cpu_rdata3, e.data);
        chk("l3_ret_cycle", cyc, e.due);
      end
    end
    while (q3.size() > 0 && q3[0].due < cyc) begin
      chk("l3_missing_rvalid", cyc, q3[0].due);
      void'(q3.pop_front());
    end
  end

  // One bus cycle: drive, check grants mid-cycle, push expected reads, check command after edge
  task automatic step(input logic creq, input logic cwe, input logic [0:31] caddr, input logic [0:63] cwd,
                      input logic nreq, input logic nwe, input logic [0:31] naddr, input logic [0:63] nwd);
    logic ecg, eng, en, swe;
    logic [0:31] sa;
    logic [0:63] sd;
    ret_t e;
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    nic_req = nreq; nic_we = nwe; nic_addr = naddr; nic_wdata = nwd;
    @(negedge clk);
    ecg = creq & (~nreq | ~mprio);
    eng = nreq & (~creq | mprio);
    chk("cpu_gnt", cpu_gnt1, ecg);
    chk("nic_gnt", nic_gnt1, eng);
    chk("cpu_gnt_l3", cpu_gnt3, ecg);
    chk("nic_gnt_l3", nic_gnt3, eng);
    en  = (ecg | eng) & ~reset;
    swe = ecg ? cwe : nwe;
    sa  = ecg ? caddr : naddr;
    sd  = ecg ? cwd : nwd;
    if (en && !swe) begin
      e.port = eng;
      e.data = memfn(sa);
      e.due  = cyc + 2;
      q1.push_back(e);
      e.due  = cyc + 4;
      q3.push_back(e);
    end
    if (reset) mprio = 1'b0;
    else if (ecg | eng) mprio = ecg;
    @(posedge clk);
    #1;
    if (reset) begin
      q1.delete();
      q3.delete();
    end
    chk("memEn", memEn1, en);
    chk("memWrEn", memWrEn1, en & swe);
    chk("addr_out", addr_out1, en ? sa : 32'h0);
    chk("d_out", d_out1, (en & swe) ? sd : 64'h0);
    chk("memEn_l3", memEn3, en);
    chk("addr_out_l3", addr_out3, en ? sa : 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [0:31] ra, rb;
    logic [0:63] rw;
    @(posedge clk);
    #1;
    // reset with both ports requesting
    reset = 1'b1;
    step(1, 0, 32'h40, 0, 1, 0, 32'h50, 0);
    step(1, 0, 32'h40, 0, 1, 0, 32'h50, 0);
    chk("rst_cpu_rvalid", cpu_rvalid1, 0);
    chk("rst_nic_rvalid", nic_rvalid1, 0);
    chk("rst_cpu_rvalid_l3", cpu_rvalid3, 0);
    reset = 1'b0;
    step(1, 0, 32'h40, 0, 1, 0, 32'h50, 0);
    step(0, 0, 0, 0, 1, 0, 32'h50, 0);
    idle(5);
    // single CPU load of the known word
    step(1, 0, 32'h10, 0, 0, 0, 0, 0);
    idle(5);
    // contention: both hold reads for four cycles
    for (int i = 0; i < 4; i++) step(1, 0, 32'h200 + i, 0, 1, 0, 32'h300 + i, 0);
    idle(5);
    // NIC store, then CPU store
    step(0, 0, 0, 0, 1, 1, 32'h20, 64'h1234);
    step(1, 1, 32'h24, 64'hCAFE_F00D_0000_0001, 0, 0, 0, 0);
    idle(5);
    // back-to-back CPU reads
    step(1, 0, 32'h100, 0, 0, 0, 0, 0);
    step(1, 0, 32'h104, 0, 0, 0, 0, 0);
    step(1, 0, 32'h108, 0, 0, 0, 0, 0);
    idle(6);
    // reset mid-flight: NIC read, CPU read, then reset
    step(0, 0, 0, 0, 1, 0, 32'h400, 0);
    step(1, 0, 32'h404, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    idle(5);
    step(1, 0, 32'h500, 0, 1, 0, 32'h504, 0);
    idle(5);
    // random mix of requests, loads and stores
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      rw = {$urandom, $urandom};
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rw,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rb, ~rw);
    end
    idle(6);
    chk("l1_queue_drained", q1.size(), 0);
    chk("l3_queue_drained", q3.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
